// File: rtl/mem_pkg.sv
// Shared constants and types for the MEM-stage data memory access unit.
package mem_pkg;

  // Major opcodes seen in the MEM stage
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  // Access size codes carried in funct3[1:0]; code 11 behaves as a word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Memory access sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RSP  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Bit shift that brings the addressed byte lane down to bit 0
  function automatic logic [4:0] lane_shift(input logic [1:0] byte_off);
    return {byte_off, 3'b000};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Store lane steering: byte enables, replicated write data and alignment check.
module mem_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            size,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  misaligned
);

  // Decode access size into lane enables, replicated data and alignment fault
  always_comb begin
    be         = 4'b1111;
    wdata      = wd;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {(DATA_WIDTH/8){wd[7:0]}};
      end
      SZ_HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {(DATA_WIDTH/16){wd[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns a pipeline memory access into a
// valid/ready request plus response wait, stalling IF..MEM meanwhile.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode_M,
  input  logic [2:0]            funct3_M,
  input  logic                  MemWrite_M,
  input  logic [ADDR_WIDTH-1:0] ALU_result_M,
  input  logic [DATA_WIDTH-1:0] WriteData_M,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rsp_rdata,
  output logic [DATA_WIDTH-1:0] ReadData_M,
  output logic                  stall_M,
  output logic                  misaligned_M
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic [1:0]            off_q;
  logic                  we_q;
  logic                  req_valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  is_load;
  logic                  is_access;
  logic                  go;
  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic                  misaligned_c;

  // Sign handling happens downstream, so funct3[2] is not needed here
  logic                  unused_f3;
  assign unused_f3 = funct3_M[2];

  assign is_load   = (opcode_M == LOAD);
  assign is_access = is_load | MemWrite_M;
  assign go        = is_access & ~misaligned_c;

  mem_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .size       (funct3_M[1:0]),
    .addr_lo    (ALU_result_M[1:0]),
    .wd         (WriteData_M),
    .be         (be_c),
    .wdata      (wdata_c),
    .misaligned (misaligned_c)
  );

  // Access sequencer: latch request, hold it until accepted, wait for load data
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      req_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state       <= REQ;
            addr_q      <= {ALU_result_M[ADDR_WIDTH-1:2], 2'b00};
            off_q       <= ALU_result_M[1:0];
            be_q        <= be_c;
            wdata_q     <= wdata_c;
            we_q        <= MemWrite_M;
            req_valid_q <= 1'b1;
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            state       <= we_q ? DONE : RSP;
          end
        end
        RSP: begin
          if (dmem_rsp_valid) begin
            rdata_q <= dmem_rsp_rdata >> lane_shift(off_q);
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dmem_req_valid = req_valid_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;
  assign misaligned_M   = misaligned_c;

  // Stall starts in the same cycle the access is seen and ends on DONE
  assign stall_M = ((state == IDLE) & go) | (state == REQ) | (state == RSP);

  // A faulting access must not forward stale load data
  assign ReadData_M = ((state == IDLE) & is_access & misaligned_c) ? '0 : rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode_M;
  logic [2:0]    funct3_M;
  logic          MemWrite_M;
  logic [AW-1:0] ALU_result_M;
  logic [DW-1:0] WriteData_M;
  logic          dmem_req_valid;
  logic          dmem_req_ready;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [3:0]    dmem_be;
  logic          dmem_rsp_valid;
  logic [DW-1:0] dmem_rsp_rdata;
  logic [DW-1:0] ReadData_M;
  logic          stall_M;
  logic          misaligned_M;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .opcode_M       (opcode_M),
    .funct3_M       (funct3_M),
    .MemWrite_M     (MemWrite_M),
    .ALU_result_M   (ALU_result_M),
    .WriteData_M    (WriteData_M),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .ReadData_M     (ReadData_M),
    .stall_M        (stall_M),
    .misaligned_M   (misaligned_M)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    opcode_M     = 7'b0010011;
    funct3_M     = 3'b000;
    MemWrite_M   = 1'b0;
    ALU_result_M = '0;
    WriteData_M  = '0;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [AW-1:0] a);
    opcode_M     = LOAD;
    funct3_M     = f3;
    MemWrite_M   = 1'b0;
    ALU_result_M = a;
    WriteData_M  = '0;
  endtask

  task automatic drive_store(input logic [2:0] f3, input logic [AW-1:0] a, input logic [DW-1:0] d);
    opcode_M     = STORE;
    funct3_M     = f3;
    MemWrite_M   = 1'b1;
    ALU_result_M = a;
    WriteData_M  = d;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({dmem_req_valid, dmem_we, stall_M, ReadData_M} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_ctrl got=%h exp=%h", {dmem_req_valid, dmem_we, stall_M, ReadData_M}, 35'h0);
    end
    checks++;
    if ({dmem_addr, dmem_be, dmem_wdata} !== 68'h0) begin
      failures++;
      $display("FAIL reset_req got=%h exp=%h", {dmem_addr, dmem_be, dmem_wdata}, 68'h0);
    end
    // Non-access with a stray response: nothing happens
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'hCAFEF00D;
    step();
    dmem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({dmem_req_valid, stall_M, ReadData_M} !== {1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL nonaccess_idle got=%h exp=%h", {dmem_req_valid, stall_M, ReadData_M}, 34'h0);
    end
  endtask

  task automatic test_store_word();
    int cnt;
    drive_store(3'b010, 32'h100, 32'hDEADBEEF);
    dmem_req_ready = 1'b1;
    #1;
    checks++;
    if ({stall_M, dmem_req_valid, misaligned_M} !== 3'b100) begin
      failures++;
      $display("FAIL sw_idle got=%b exp=%b", {stall_M, dmem_req_valid, misaligned_M}, 3'b100);
    end
    cnt = int'(stall_M);
    step();
    checks++;
    if ({dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata} !==
        {1'b1, 1'b1, 4'b1111, 32'h100, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL sw_req got=%h exp=%h", {dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata},
               {1'b1, 1'b1, 4'b1111, 32'h100, 32'hDEADBEEF});
    end
    cnt += int'(stall_M);
    step();
    checks++;
    if ({dmem_req_valid, dmem_we, stall_M} !== 3'b000) begin
      failures++;
      $display("FAIL sw_done got=%b exp=%b", {dmem_req_valid, dmem_we, stall_M}, 3'b000);
    end
    checks++;
    if (cnt !== 2) begin
      failures++;
      $display("FAIL sw_stall_cycles got=%0d exp=2", cnt);
    end
    idle_inputs();
    step();
    checks++;
    if ({dmem_req_valid, stall_M} !== 2'b00) begin
      failures++;
      $display("FAIL sw_back_idle got=%b exp=%b", {dmem_req_valid, stall_M}, 2'b00);
    end
  endtask

  task automatic test_load_byte();
    int cnt;
    drive_load(3'b000, 32'h103);
    dmem_req_ready = 1'b1;
    #1;
    cnt = int'(stall_M);
    step();
    checks++;
    if ({dmem_req_valid, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b0, 4'b1000, 32'h100}) begin
      failures++;
      $display("FAIL lb_req got=%h exp=%h", {dmem_req_valid, dmem_we, dmem_be, dmem_addr},
               {1'b1, 1'b0, 4'b1000, 32'h100});
    end
    cnt += int'(stall_M);
    step();
    checks++;
    if ({dmem_req_valid, stall_M} !== 2'b01) begin
      failures++;
      $display("FAIL lb_rsp_wait got=%b exp=%b", {dmem_req_valid, stall_M}, 2'b01);
    end
    cnt += int'(stall_M);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h80112233;
    step();
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    #1;
    checks++;
    if ({stall_M, ReadData_M} !== {1'b0, 32'h00000080}) begin
      failures++;
      $display("FAIL lb_done got=%h exp=%h", {stall_M, ReadData_M}, {1'b0, 32'h00000080});
    end
    checks++;
    if (cnt !== 3) begin
      failures++;
      $display("FAIL lb_stall_cycles got=%0d exp=3", cnt);
    end
    idle_inputs();
    step();
    checks++;
    if (ReadData_M !== 32'h00000080) begin
      failures++;
      $display("FAIL lb_hold got=%h exp=%h", ReadData_M, 32'h00000080);
    end
  endtask

  task automatic test_store_sizes();
    logic [2:0]  f3_t [3] = '{3'b001, 3'b000, 3'b011};
    logic [31:0] a_t  [3] = '{32'h102, 32'h101, 32'h104};
    logic [31:0] d_t  [3] = '{32'h0000ABCD, 32'h12345655, 32'h01020304};
    logic [3:0]  be_t [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wd_t [3] = '{32'hABCDABCD, 32'h55555555, 32'h01020304};
    logic [31:0] ad_t [3] = '{32'h100, 32'h100, 32'h104};
    dmem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_store(f3_t[i], a_t[i], d_t[i]);
      step();
      checks++;
      if ({dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata} !==
          {1'b1, 1'b1, be_t[i], ad_t[i], wd_t[i]}) begin
        failures++;
        $display("FAIL store_size%0d got=%h exp=%h", i, {dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata},
                 {1'b1, 1'b1, be_t[i], ad_t[i], wd_t[i]});
      end
      step();
      idle_inputs();
      step();
    end
  endtask

  task automatic test_misaligned();
    drive_load(3'b010, 32'h101);
    #1;
    checks++;
    if ({misaligned_M, dmem_req_valid, stall_M, ReadData_M} !== {3'b100, 32'h0}) begin
      failures++;
      $display("FAIL lw_misaligned got=%h exp=%h", {misaligned_M, dmem_req_valid, stall_M, ReadData_M}, {3'b100, 32'h0});
    end
    step();
    checks++;
    if ({dmem_req_valid, stall_M, ReadData_M} !== {2'b00, 32'h0}) begin
      failures++;
      $display("FAIL lw_misaligned_norq got=%h exp=%h", {dmem_req_valid, stall_M, ReadData_M}, {2'b00, 32'h0});
    end
    drive_store(3'b001, 32'h103, 32'h1111);
    #1;
    checks++;
    if ({misaligned_M, stall_M} !== 2'b10) begin
      failures++;
      $display("FAIL sh_misaligned got=%b exp=%b", {misaligned_M, stall_M}, 2'b10);
    end
    drive_load(3'b001, 32'h102);
    #1;
    checks++;
    if ({misaligned_M, stall_M} !== 2'b01) begin
      failures++;
      $display("FAIL lh_aligned got=%b exp=%b", {misaligned_M, stall_M}, 2'b01);
    end
    idle_inputs();
    #1;
    checks++;
    if (ReadData_M !== 32'h00000080) begin
      failures++;
      $display("FAIL misaligned_restore got=%h exp=%h", ReadData_M, 32'h00000080);
    end
    step();
  endtask

  task automatic test_ready_stall();
    int cnt;
    drive_load(3'b010, 32'h200);
    dmem_req_ready = 1'b0;
    #1;
    cnt = int'(stall_M);
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({dmem_req_valid, dmem_addr, dmem_be, stall_M} !== {1'b1, 32'h200, 4'b1111, 1'b1}) begin
        failures++;
        $display("FAIL ready_low_req%0d got=%h exp=%h", i, {dmem_req_valid, dmem_addr, dmem_be, stall_M},
                 {1'b1, 32'h200, 4'b1111, 1'b1});
      end
      cnt += int'(stall_M);
      dmem_rsp_valid = (i == 1);
      dmem_rsp_rdata = (i == 1) ? 32'hBAD0BAD0 : 32'h0;
      dmem_req_ready = (i == 4);
      step();
    end
    dmem_req_ready = 1'b0;
    cnt += int'(stall_M);
    step();
    checks++;
    if ({stall_M, dmem_req_valid, ReadData_M} !== {2'b10, 32'h00000080}) begin
      failures++;
      $display("FAIL rsp_wait got=%h exp=%h", {stall_M, dmem_req_valid, ReadData_M}, {2'b10, 32'h00000080});
    end
    cnt += int'(stall_M);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h12345678;
    step();
    dmem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({stall_M, ReadData_M} !== {1'b0, 32'h12345678}) begin
      failures++;
      $display("FAIL ready_low_done got=%h exp=%h", {stall_M, ReadData_M}, {1'b0, 32'h12345678});
    end
    checks++;
    if (cnt !== 8) begin
      failures++;
      $display("FAIL ready_low_stall_cycles got=%0d exp=8", cnt);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_in_rsp();
    drive_load(3'b010, 32'h300);
    dmem_req_ready = 1'b1;
    step();
    step();
    checks++;
    if ({stall_M, dmem_req_valid} !== 2'b10) begin
      failures++;
      $display("FAIL pre_reset_rsp got=%b exp=%b", {stall_M, dmem_req_valid}, 2'b10);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if ({dmem_req_valid, stall_M, ReadData_M, dmem_addr} !== {2'b00, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_abandon got=%h exp=%h", {dmem_req_valid, stall_M, ReadData_M, dmem_addr}, 66'h0);
    end
    step();
    dmem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({stall_M, ReadData_M} !== 33'h0) begin
      failures++;
      $display("FAIL late_rsp_ignored got=%h exp=%h", {stall_M, ReadData_M}, 33'h0);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_sizes();
    test_misaligned();
    test_ready_stall();
    test_reset_in_rsp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 32 and set the data bus width.
REQ-002 Parameter ADDR_WIDTH SHALL default to 32 and set the address width.
REQ-003 The port list SHALL be as follows (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- opcode_M  in  7  MEM-stage opcode; 0000011 = load.
- funct3_M  in  3  access size/sign code.
- MemWrite_M  in  1  store in MEM stage.
- ALU_result_M  in  ADDR_WIDTH  byte address.
- WriteData_M  in  DATA_WIDTH  store data, right-justified.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_WIDTH  word-aligned address, with [1:0] = 0.
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rsp_valid  in  1  read data valid.
- dmem_rsp_rdata  in  DATA_WIDTH  read word.
- ReadData_M  out  DATA_WIDTH  load data, right-justified, not extended; feeds the MEM/WB register.
- stall_M  out  1  freeze IF..MEM.
- misaligned_M  out  1  misaligned-access flag.

Function
REQ-004 An access SHALL be a load (opcode_M = 0000011) or a store (MemWrite_M = 1).
REQ-005 Size SHALL follow funct3_M[1:0]: 00 = byte, 01 = half, 10 = word; code 11 SHALL be treated as word.
REQ-006 misaligned_M SHALL be combinational: a half access with addr[0] = 1, or a word access with addr[1:0] != 0.
REQ-007 A misaligned access SHALL issue no request and assert no stall, and ReadData_M SHALL be 0.
REQ-008 FSM states SHALL be IDLE, REQ, RSP and DONE.
REQ-009 IDLE: an aligned access SHALL go to REQ, with stall_M asserted combinationally in the same cycle.
REQ-010 IDLE: address, byte enables, wdata and we SHALL be latched into internal registers on entry to REQ.
REQ-011 REQ: dmem_req_valid SHALL be 1, and all request fields SHALL stay stable until dmem_req_ready = 1.
REQ-012 REQ on handshake: a store SHALL go to DONE; a load SHALL go to RSP.
REQ-013 RSP: the FSM SHALL wait for dmem_rsp_valid, then capture dmem_rsp_rdata >> (8*addr[1:0]) and go to DONE.
REQ-014 dmem_rsp_valid SHALL be ignored in every state except RSP.
REQ-015 DONE: stall_M SHALL be 0 for exactly one cycle, ReadData_M SHALL present the captured data, and the next state SHALL be IDLE.
REQ-016 stall_M SHALL equal (IDLE and aligned access) or REQ or RSP.
REQ-017 Minimum latency: a load SHALL stall 3 cycles and a store 2 cycles.
REQ-018 Byte enables: byte = 0001 << addr[1:0]; half = 0011 << addr[1:0]; word = 1111.
REQ-019 wdata: byte = {4{wd[7:0]}}; half = {2{wd[15:0]}}; word = wd.
REQ-020 dmem_addr SHALL be {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-021 A non-access in IDLE SHALL hold stall_M = 0 and dmem_req_valid = 0.
REQ-022 dmem_we = 1 SHALL be driven only for store requests.
REQ-023 Outside DONE, ReadData_M SHALL hold the last captured value.

Reset
REQ-024 With rst = 1 at a clock edge, the state SHALL become IDLE and the captured data and latched request SHALL become 0.
REQ-025 After reset, dmem_req_valid and stall_M SHALL be 0, and ReadData_M SHALL be 0.
REQ-026 A reset in REQ or RSP SHALL abandon the access; a late dmem_rsp_valid SHALL then be ignored.

Structure
REQ-027 Package mem_pkg SHALL hold the opcode constants (LOAD, STORE), the funct3 size codes and the FSM state enum.
REQ-028 Sub-module mem_align (combinational) SHALL produce dmem_be, replicated wdata and misaligned_M from size, addr[1:0] and store data.

Verification
REQ-029 SW to 0x100, data 0xDEADBEEF, with ready = 1 -> one request: be = 1111, we = 1; stall high 2 cycles.
REQ-030 LB from 0x103, memory word 0x80112233, rsp one cycle after handshake -> ReadData_M = 0x00000080 in DONE; stall 3 cycles.
REQ-031 SH to 0x102, data 0x0000ABCD -> be = 1100, wdata = 0xABCDABCD, addr = 0x100.
REQ-032 LW to 0x101 -> misaligned_M = 1, no request, stall_M = 0, ReadData_M = 0.
REQ-033 Load with ready held low 4 cycles -> valid, addr and be stable throughout; stall held until DONE.
REQ-034 rst pulsed during RSP, then rsp_valid arrives -> IDLE, response ignored, ReadData_M = 0.
